// File: rtl/hilo_divider.sv
// Sequential 32-bit unsigned restoring divider with HI (remainder) / LO (quotient) result registers.
// A DIVU code on Signal starts a 32-step division; results are published only on completion.
module hilo_divider #(
    parameter logic [3:0] DIVU = 4'b0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [3:0]  Signal,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [32:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    logic [33:0] shift_rem;
    logic [33:0] trial;
    logic [32:0] rem_d;
    logic [31:0] quo_d;

    // One restoring step: shift {rem, quo} left, trial-subtract, restore on borrow.
    always_comb begin
        shift_rem = {rem_q, quo_q[31]};
        trial     = shift_rem - {2'b00, dvs_q};
        if (trial[33]) begin
            rem_d = shift_rem[32:0];
            quo_d = {quo_q[30:0], 1'b0};
        end else begin
            rem_d = trial[32:0];
            quo_d = {quo_q[30:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (Signal == DIVU) begin
                    quo_q   <= dataA;
                    dvs_q   <= dataB;
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= RUN;
                end
            end else begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q + 5'd1;
                // Last step publishes straight from the step logic so the result lands with done.
                if (cnt_q == 5'd31) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    hi_q    <= rem_d[31:0];
                    lo_q    <= quo_d;
                end
            end
        end
    end

    assign HiOut = hi_q;
    assign LoOut = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
